// File: rtl/sram_ctl_pkg.sv
// Shared SRAM-controller definitions: write-arbiter FSM encoding and the
// default bus widths also used by the datasg segmenters.
package sram_ctl_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_e;

   localparam int DEF_DATA_WIDTH = 64;
   localparam int DEF_ADDR_WIDTH = 12;
   localparam int DEF_DES_WIDTH  = 4;
   localparam int DEF_PRI_WIDTH  = 3;
   localparam int DEF_NUM_PORTS  = 4;
   localparam int DEF_MAX_BURST  = 16;

   // Width of a port index; NUM_PORTS is a power of two so indices wrap for free.
   function automatic int port_idx_width(input int num_ports);
      return (num_ports > 1) ? $clog2(num_ports) : 1;
   endfunction

endpackage

// File: rtl/sram_wr_arbiter_if.sv
// Segmenter-array / SRAM-write bundle seen by the write arbiter.
// The master modport is the arbiter; the slave modport is its environment.
interface sram_wr_arbiter_if #(
   parameter int NUM_PORTS  = sram_ctl_pkg::DEF_NUM_PORTS,
   parameter int DATA_WIDTH = sram_ctl_pkg::DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = sram_ctl_pkg::DEF_ADDR_WIDTH,
   parameter int DES_WIDTH  = sram_ctl_pkg::DEF_DES_WIDTH,
   parameter int PRI_WIDTH  = sram_ctl_pkg::DEF_PRI_WIDTH
) ();
   import sram_ctl_pkg::*;

   localparam int IW = port_idx_width(NUM_PORTS);

   logic [NUM_PORTS-1:0]            req;
   logic [NUM_PORTS*PRI_WIDTH-1:0]  req_priority;
   logic [NUM_PORTS*DES_WIDTH-1:0]  req_des;
   logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_PORTS*DATA_WIDTH-1:0] req_data;
   logic [NUM_PORTS-1:0]            busy;
   logic [NUM_PORTS-1:0]            transfering;
   logic                            sram_ready;
   logic                            sram_wr_en;
   logic [ADDR_WIDTH-1:0]           sram_addr;
   logic [DATA_WIDTH-1:0]           sram_data;
   logic [DES_WIDTH-1:0]            sram_des;
   logic [PRI_WIDTH-1:0]            sram_priority;
   logic [IW-1:0]                   grant_id;

   modport master (
      input  req, req_priority, req_des, req_addr, req_data, sram_ready,
      output busy, transfering, sram_wr_en, sram_addr, sram_data, sram_des,
             sram_priority, grant_id
   );

   modport slave (
      output req, req_priority, req_des, req_addr, req_data, sram_ready,
      input  busy, transfering, sram_wr_en, sram_addr, sram_data, sram_des,
             sram_priority, grant_id
   );

endinterface

// File: rtl/sram_wr_pick.sv
// Combinational winner selection: highest priority among requesters, ties
// broken by the first eligible port at or after rr_ptr (wrapping upward).
module sram_wr_pick
   import sram_ctl_pkg::*;
#(
   parameter int  NUM_PORTS = DEF_NUM_PORTS,
   parameter int  PRI_WIDTH = DEF_PRI_WIDTH,
   localparam int IW        = port_idx_width(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0]           req,
   input  logic [NUM_PORTS*PRI_WIDTH-1:0] req_priority,
   input  logic [IW-1:0]                  rr_ptr,
   output logic [IW-1:0]                  winner,
   output logic                           valid
);

   logic [PRI_WIDTH-1:0] pri_a [NUM_PORTS];
   logic [PRI_WIDTH-1:0] max_pri;
   logic [NUM_PORTS-1:0] eligible;
   logic [IW-1:0]        scan_idx;
   logic                 found;

   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         assign pri_a[gi]    = req_priority[gi*PRI_WIDTH +: PRI_WIDTH];
         assign eligible[gi] = req[gi] && (pri_a[gi] == max_pri);
      end
   endgenerate

   always_comb begin
      max_pri = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (req[i] && (pri_a[i] > max_pri)) begin
            max_pri = pri_a[i];
         end
      end
   end

   // Index arithmetic wraps naturally because NUM_PORTS is a power of two.
   always_comb begin
      winner   = '0;
      found    = 1'b0;
      scan_idx = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         scan_idx = rr_ptr + IW'(k);
         if (!found && eligible[scan_idx]) begin
            winner = scan_idx;
            found  = 1'b1;
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/sram_wr_arbiter.sv
// Shares the SRAM write port among NUM_PORTS segmenters: strict priority with
// round-robin tie-break, bursts of up to MAX_BURST words per grant.
module sram_wr_arbiter
   import sram_ctl_pkg::*;
#(
   parameter int NUM_PORTS  = DEF_NUM_PORTS,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DES_WIDTH  = DEF_DES_WIDTH,
   parameter int PRI_WIDTH  = DEF_PRI_WIDTH,
   parameter int MAX_BURST  = DEF_MAX_BURST
) (
   input logic               clk,
   input logic               rst,
   sram_wr_arbiter_if.master bus
);

   localparam int            IW       = port_idx_width(NUM_PORTS);
   localparam int            CW       = $clog2(MAX_BURST) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

   arb_state_e            state_q;
   logic [IW-1:0]         gnt_q;
   logic [IW-1:0]         rr_ptr_q;
   logic [CW-1:0]         cnt_q;
   logic                  sram_wr_en_q;
   logic [ADDR_WIDTH-1:0] sram_addr_q;
   logic [DATA_WIDTH-1:0] sram_data_q;
   logic [DES_WIDTH-1:0]  sram_des_q;
   logic [PRI_WIDTH-1:0]  sram_priority_q;

   logic [ADDR_WIDTH-1:0] addr_a [NUM_PORTS];
   logic [DATA_WIDTH-1:0] data_a [NUM_PORTS];
   logic [DES_WIDTH-1:0]  des_a  [NUM_PORTS];
   logic [PRI_WIDTH-1:0]  pri_a  [NUM_PORTS];

   logic [IW-1:0]         pick_winner;
   logic                  pick_valid;
   logic                  gnt_req;
   logic                  word_accept;
   logic                  grant_release;
   logic [NUM_PORTS-1:0]  busy_vec;
   logic [NUM_PORTS-1:0]  xfer_vec;

   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         assign addr_a[gi]   = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign data_a[gi]   = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
         assign des_a[gi]    = bus.req_des[gi*DES_WIDTH +: DES_WIDTH];
         assign pri_a[gi]    = bus.req_priority[gi*PRI_WIDTH +: PRI_WIDTH];
         assign xfer_vec[gi] = word_accept && (gnt_q == IW'(gi));
         assign busy_vec[gi] = (state_q == XFER) &&
                               ((gnt_q != IW'(gi)) || !bus.sram_ready);
      end
   endgenerate

   sram_wr_pick #(
      .NUM_PORTS (NUM_PORTS),
      .PRI_WIDTH (PRI_WIDTH)
   ) u_pick (
      .req          (bus.req),
      .req_priority (bus.req_priority),
      .rr_ptr       (rr_ptr_q),
      .winner       (pick_winner),
      .valid        (pick_valid)
   );

   assign gnt_req     = bus.req[gnt_q];
   assign word_accept = (state_q == XFER) && gnt_req && bus.sram_ready;
   // A dropped request ends the grant even under stall; otherwise the cap does.
   assign grant_release = (state_q == XFER) &&
                          (!gnt_req || (bus.sram_ready && (cnt_q == LAST_CNT)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= IDLE;
         gnt_q           <= '0;
         rr_ptr_q        <= '0;
         cnt_q           <= '0;
         sram_wr_en_q    <= 1'b0;
         sram_addr_q     <= '0;
         sram_data_q     <= '0;
         sram_des_q      <= '0;
         sram_priority_q <= '0;
      end else begin
         sram_wr_en_q <= word_accept;
         if (word_accept) begin
            sram_addr_q     <= addr_a[gnt_q];
            sram_data_q     <= data_a[gnt_q];
            sram_des_q      <= des_a[gnt_q];
            sram_priority_q <= pri_a[gnt_q];
            cnt_q           <= cnt_q + CW'(1);
         end
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  gnt_q   <= pick_winner;
                  cnt_q   <= '0;
                  state_q <= XFER;
               end
            end
            XFER: begin
               if (grant_release) begin
                  state_q  <= IDLE;
                  rr_ptr_q <= gnt_q + IW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy          = busy_vec;
   assign bus.transfering   = xfer_vec;
   assign bus.sram_wr_en    = sram_wr_en_q;
   assign bus.sram_addr     = sram_addr_q;
   assign bus.sram_data     = sram_data_q;
   assign bus.sram_des      = sram_des_q;
   assign bus.sram_priority = sram_priority_q;
   assign bus.grant_id      = gnt_q;

endmodule

// File: tb/tb_sram_wr_arbiter.sv
// Directed bench for sram_wr_arbiter: expected writes are queued as words are
// offered and checked against the registered SRAM write port.
module tb_sram_wr_arbiter;

   localparam int NP = 4;

   typedef struct {
      logic [11:0] addr;
      logic [63:0] data;
      logic [3:0]  des;
      logic [2:0]  pri;
   } wr_t;

   logic clk;
   logic rst;

   logic [3:0]  req_v;
   logic        ready_v;
   logic [2:0]  pri_v  [NP];
   logic [3:0]  des_v  [NP];
   logic [11:0] addr_v [NP];
   logic [63:0] data_v [NP];

   wr_t         sb [$];
   wr_t         mon_e;
   int          n_checks = 0;
   int          n_pass   = 0;
   logic        prev_wr  = 1'b0;
   logic [63:0] last_data = '0;

   sram_wr_arbiter_if #(
      .NUM_PORTS (4), .DATA_WIDTH (64), .ADDR_WIDTH (12),
      .DES_WIDTH (4), .PRI_WIDTH (3)
   ) bus ();

   sram_wr_arbiter #(
      .NUM_PORTS (4), .DATA_WIDTH (64), .ADDR_WIDTH (12),
      .DES_WIDTH (4), .PRI_WIDTH (3), .MAX_BURST (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      bus.req          = req_v;
      bus.sram_ready   = ready_v;
      bus.req_priority = '0;
      bus.req_des      = '0;
      bus.req_addr     = '0;
      bus.req_data     = '0;
      for (int i = 0; i < NP; i++) begin
         bus.req_priority[i*3 +: 3]  = pri_v[i];
         bus.req_des[i*4 +: 4]       = des_v[i];
         bus.req_addr[i*12 +: 12]    = addr_v[i];
         bus.req_data[i*64 +: 64]    = data_v[i];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks = n_checks + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic new_word(input int p);
      addr_v[p] = 12'($urandom);
      data_v[p] = {$urandom, $urandom};
      des_v[p]  = 4'($urandom);
   endtask

   // One cycle: acc is the port whose word must be consumed (-1 for none).
   task automatic tick(input int acc, input bit push, input logic [3:0] exp_busy);
      logic [3:0] exp_xfer;
      exp_xfer = (acc >= 0) ? (4'b0001 << acc) : 4'b0000;
      @(negedge clk);
      chk("transfering", bus.transfering, exp_xfer);
      chk("busy", bus.busy, exp_busy);
      chk("sram_wr_en", bus.sram_wr_en, prev_wr);
      if (!prev_wr) chk("sram_data_hold", bus.sram_data, last_data);
      if (acc >= 0) begin
         chk("grant_id", bus.grant_id, acc);
         if (push) begin
            sb.push_back('{addr_v[acc], data_v[acc], des_v[acc], pri_v[acc]});
            last_data = data_v[acc];
         end
      end
      prev_wr = (acc >= 0) && push;
      @(posedge clk);
      #1;
      if (acc >= 0) new_word(acc);
   endtask

   task automatic chk_reset_outputs();
      @(negedge clk);
      chk("rst_wr_en", bus.sram_wr_en, 0);
      chk("rst_addr", bus.sram_addr, 0);
      chk("rst_data", bus.sram_data, 0);
      chk("rst_des", bus.sram_des, 0);
      chk("rst_priority", bus.sram_priority, 0);
      chk("rst_grant_id", bus.grant_id, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_transfering", bus.transfering, 0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      chk_reset_outputs();
      @(posedge clk);
      #1;
      rst       = 1'b1;
      prev_wr   = 1'b0;
      last_data = '0;
   endtask

   always @(negedge clk) begin
      if (rst && bus.sram_wr_en) begin
         if (sb.size() == 0) begin
            chk("unexpected_write", bus.sram_wr_en, 0);
         end else begin
            mon_e = sb.pop_front();
            $display("write addr=%03h data=%016h des=%0h pri=%0d",
                     bus.sram_addr, bus.sram_data, bus.sram_des, bus.sram_priority);
            chk("wr_addr", bus.sram_addr, mon_e.addr);
            chk("wr_data", bus.sram_data, mon_e.data);
            chk("wr_des", bus.sram_des, mon_e.des);
            chk("wr_priority", bus.sram_priority, mon_e.pri);
         end
      end
   end

   initial begin
      // Reset held for two cycles with random inputs.
      rst     = 1'b0;
      req_v   = 4'($urandom);
      ready_v = 1'($urandom);
      for (int i = 0; i < NP; i++) begin
         pri_v[i] = 3'($urandom);
         new_word(i);
      end
      chk_reset_outputs();
      req_v   = 4'($urandom);
      ready_v = 1'($urandom);
      chk_reset_outputs();
      @(posedge clk);
      #1;
      req_v   = 4'b0000;
      ready_v = 1'b1;
      rst     = 1'b1;
      tick(-1, 0, 4'b0000);
      tick(-1, 0, 4'b0000);

      // Priority: port2 (5) beats port1 (2), three words.
      pri_v[1] = 3'd2;
      pri_v[2] = 3'd5;
      req_v    = 4'b0110;
      tick(-1, 0, 4'b0000);
      for (int w = 0; w < 3; w++) tick(2, 1, 4'b1011);
      req_v = 4'b0000;
      tick(-1, 0, 4'b1011);
      tick(-1, 0, 4'b0000);

      // Round-robin among equal priorities, single-word grants.
      do_reset();
      for (int i = 0; i < NP; i++) pri_v[i] = 3'd3;
      req_v = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         tick(-1, 0, 4'b0000);
         tick(g % NP, 1, ~(4'b0001 << (g % NP)));
         req_v[g % NP] = 1'b0;
         tick(-1, 0, ~(4'b0001 << (g % NP)));
         req_v[g % NP] = 1'b1;
      end
      req_v = 4'b0000;
      tick(-1, 0, 4'b0000);

      // Backpressure: two stall cycles mid-burst on port0.
      pri_v[0] = 3'd1;
      req_v    = 4'b0001;
      tick(-1, 0, 4'b0000);
      tick(0, 1, 4'b1110);
      tick(0, 1, 4'b1110);
      ready_v = 1'b0;
      tick(-1, 0, 4'b1111);
      tick(-1, 0, 4'b1111);
      ready_v = 1'b1;
      tick(0, 1, 4'b1110);
      tick(0, 1, 4'b1110);
      req_v = 4'b0000;
      tick(-1, 0, 4'b1110);
      tick(-1, 0, 4'b0000);

      // Burst cap, port3 alone: 16 words, IDLE, then re-granted.
      pri_v[3] = 3'd4;
      req_v    = 4'b1000;
      tick(-1, 0, 4'b0000);
      for (int w = 0; w < 16; w++) tick(3, 1, 4'b0111);
      tick(-1, 0, 4'b0000);
      tick(3, 1, 4'b0111);
      tick(3, 1, 4'b0111);
      req_v = 4'b0000;
      tick(-1, 0, 4'b0111);
      tick(-1, 0, 4'b0000);

      // Burst cap with an equal-priority competitor: port1 wins after the cap.
      pri_v[1] = 3'd4;
      req_v    = 4'b1000;
      tick(-1, 0, 4'b0000);
      tick(3, 1, 4'b0111);
      req_v[1] = 1'b1;
      for (int w = 0; w < 15; w++) tick(3, 1, 4'b0111);
      tick(-1, 0, 4'b0000);
      tick(1, 1, 4'b1101);
      req_v = 4'b0000;
      tick(-1, 0, 4'b1101);
      tick(-1, 0, 4'b0000);

      // Reset after the fifth accepted word of a port2 burst.
      pri_v[2] = 3'd2;
      req_v    = 4'b0100;
      tick(-1, 0, 4'b0000);
      for (int w = 0; w < 4; w++) tick(2, 1, 4'b1011);
      tick(2, 0, 4'b1011);
      rst = 1'b0;
      for (int i = 0; i < NP; i++) pri_v[i] = 3'd2;
      req_v = 4'b1111;
      #1;
      chk("rst_async_wr_en", bus.sram_wr_en, 0);
      chk_reset_outputs();
      @(posedge clk);
      #1;
      rst       = 1'b1;
      prev_wr   = 1'b0;
      last_data = '0;
      tick(-1, 0, 4'b0000);
      tick(0, 1, 4'b1110);
      req_v = 4'b0000;
      tick(-1, 0, 4'b1110);
      tick(-1, 0, 4'b0000);

      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
